// File: rtl/br_arb_rr_packet_lock.sv
// Round-robin packet arbiter: N valid/ready sources share one downstream channel.
// Arbitration happens only between packets. The winner of a multi-beat packet keeps
// the grant until its last beat is accepted. Priority rotates when a packet completes.
module br_arb_rr_packet_lock #(
   parameter int unsigned NumRequesters = 2,
   parameter int unsigned DataWidth     = 8,
   localparam int unsigned SrcWidth     = $clog2(NumRequesters)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NumRequesters-1:0]            push_valid,
   output logic [NumRequesters-1:0]            push_ready,
   input  logic [NumRequesters*DataWidth-1:0]  push_data,
   input  logic [NumRequesters-1:0]            push_last,
   output logic                                pop_valid,
   input  logic                                pop_ready,
   output logic [DataWidth-1:0]                pop_data,
   output logic                                pop_last,
   output logic [SrcWidth-1:0]                 pop_src,
   output logic                                locked
);

   logic                     locked_q, locked_d;
   logic [SrcWidth-1:0]      owner_q, owner_d;
   logic [SrcWidth-1:0]      prio_q, prio_d;

   logic                     rr_found;
   logic [SrcWidth-1:0]      rr_idx;
   logic [SrcWidth-1:0]      cand;
   logic                     sel_valid;
   logic [SrcWidth-1:0]      sel_idx;
   logic [NumRequesters-1:0] grant;

   // Increment modulo NumRequesters so prio never leaves 0..N-1 for non-power-of-2 N.
   function automatic logic [SrcWidth-1:0] next_idx(input logic [SrcWidth-1:0] idx);
      if (idx == SrcWidth'(NumRequesters - 1)) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

   // Round-robin search starting at prio, wrapping mod N; first valid source wins.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int unsigned k = 0; k < NumRequesters; k++) begin
         cand = SrcWidth'((32'(prio_q) + k) % NumRequesters);
         if (!rr_found && push_valid[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
   end

   // While locked only the owner may be granted; everyone else is masked.
   always_comb begin
      if (locked_q) begin
         sel_valid = push_valid[owner_q];
         sel_idx   = owner_q;
      end else begin
         sel_valid = rr_found;
         sel_idx   = rr_idx;
      end
   end

   // Output mux; all payload outputs read zero when nothing is granted.
   always_comb begin
      grant    = '0;
      pop_data = '0;
      pop_last = 1'b0;
      pop_src  = '0;
      if (sel_valid) begin
         grant[sel_idx] = 1'b1;
         pop_data       = push_data[sel_idx*DataWidth +: DataWidth];
         pop_last       = push_last[sel_idx];
         pop_src        = sel_idx;
      end
   end

   assign pop_valid  = sel_valid;
   assign push_ready = grant & {NumRequesters{pop_ready}};
   assign locked     = locked_q;

   // Lock on an accepted non-last first beat; unlock and rotate priority on an accepted last beat.
   always_comb begin
      locked_d = locked_q;
      owner_d  = owner_q;
      prio_d   = prio_q;
      if (sel_valid && pop_ready) begin
         if (pop_last) begin
            locked_d = 1'b0;
            prio_d   = next_idx(sel_idx);
         end else if (!locked_q) begin
            locked_d = 1'b1;
            owner_d  = sel_idx;
         end
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_q <= 1'b0;
         owner_q  <= '0;
         prio_q   <= '0;
      end else begin
         locked_q <= locked_d;
         owner_q  <= owner_d;
         prio_q   <= prio_d;
      end
   end

endmodule

// File: tb/tb_br_arb_rr_packet_lock.sv
// Bench for br_arb_rr_packet_lock with N=3: directed scenarios followed by random
// packet traffic, checked against a behavioural arbitration model.
module tb_br_arb_rr_packet_lock;

   localparam int N  = 3;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      push_valid;
   logic [N-1:0]      push_ready;
   logic [N*DW-1:0]   push_data;
   logic [N-1:0]      push_last;
   logic              pop_valid;
   logic              pop_ready;
   logic [DW-1:0]     pop_data;
   logic              pop_last;
   logic [1:0]        pop_src;
   logic              locked;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int m_locked;
   int m_owner;
   int m_prio;
   int rem [N];

   br_arb_rr_packet_lock #(
      .NumRequesters(N),
      .DataWidth    (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_valid(push_valid),
      .push_ready(push_ready),
      .push_data (push_data),
      .push_last (push_last),
      .pop_valid (pop_valid),
      .pop_ready (pop_ready),
      .pop_data  (pop_data),
      .pop_last  (pop_last),
      .pop_src   (pop_src),
      .locked    (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Winner according to the arbitration rules, -1 if nothing is granted.
   function automatic int model_pick();
      if (m_locked != 0) begin
         return push_valid[m_owner] ? m_owner : -1;
      end
      for (int k = 0; k < N; k++) begin
         if (push_valid[(m_prio + k) % N]) return (m_prio + k) % N;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      m_locked = 0;
      m_owner  = 0;
      m_prio   = 0;
   endfunction

   task automatic set_src(input int s, input bit v, input bit l, input logic [DW-1:0] d);
      push_valid[s]         = v;
      push_last[s]          = l;
      push_data[s*DW +: DW] = d;
   endtask

   // One cycle: check outputs against the model, clock, update the model.
   task automatic step(input string tag, output int acc);
      int          g;
      logic [N-1:0] exp_ready;
      g         = model_pick();
      exp_ready = '0;
      if (g >= 0 && pop_ready) exp_ready[g] = 1'b1;
      #1;
      check({tag, "_pop_valid"}, 32'(pop_valid), 32'(g >= 0));
      check({tag, "_pop_src"}, 32'(pop_src), (g >= 0) ? 32'(g) : 32'd0);
      check({tag, "_pop_data"}, 32'(pop_data), (g >= 0) ? 32'(push_data[g*DW +: DW]) : 32'd0);
      check({tag, "_pop_last"}, 32'(pop_last), (g >= 0) ? 32'(push_last[g]) : 32'd0);
      check({tag, "_push_ready"}, 32'(push_ready), 32'(exp_ready));
      check({tag, "_locked"}, 32'(locked), 32'(m_locked));
      acc = (g >= 0 && pop_ready) ? g : -1;
      @(posedge clk);
      if (acc >= 0) begin
         if (m_locked == 0) begin
            if (!push_last[acc]) begin
               m_locked = 1;
               m_owner  = acc;
            end else begin
               m_prio = (acc + 1) % N;
            end
         end else if (push_last[acc]) begin
            m_locked = 0;
            m_prio   = (m_owner + 1) % N;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int acc;
      push_valid = '0;
      push_last  = '0;
      push_data  = '0;
      pop_ready  = 1'b0;
      rst_n      = 1'b0;
      model_reset();
      for (int s = 0; s < N; s++) rem[s] = 0;

      // Reset state
      #1;
      check("reset_locked", 32'(locked), 32'd0);
      check("reset_pop_valid", 32'(pop_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-beat round robin: expect 0,1,2,0,1,2 with no lock
      pop_ready = 1'b1;
      for (int s = 0; s < N; s++) set_src(s, 1'b1, 1'b1, 8'(8'h10 + s));
      for (int i = 0; i < 6; i++) begin
         step("rr", acc);
         check("rr_order", 32'(acc), 32'(i % N));
      end

      // Source 0 alone so priority moves to 1
      push_valid = 3'b001;
      step("pre_lock", acc);

      // Source 1 sends 3 beats while 0 and 2 stay valid
      push_valid = 3'b111;
      set_src(1, 1'b1, 1'b0, 8'hA1);
      step("lock_b1", acc);
      check("lock_b1_src", 32'(acc), 32'd1);
      set_src(1, 1'b1, 1'b0, 8'hA2);
      step("lock_b2", acc);
      check("lock_b2_src", 32'(acc), 32'd1);
      set_src(1, 1'b1, 1'b1, 8'hA3);
      step("lock_b3", acc);
      check("lock_b3_src", 32'(acc), 32'd1);
      push_valid[1] = 1'b0;
      step("lock_next", acc);
      check("lock_next_src", 32'(acc), 32'd2);
      push_valid = '0;

      // Bubble inside a packet from source 0 while source 1 waits
      set_src(0, 1'b1, 1'b0, 8'hB0);
      set_src(1, 1'b1, 1'b1, 8'hC1);
      step("bub_first", acc);
      check("bub_first_src", 32'(acc), 32'd0);
      push_valid[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step("bubble", acc);
         check("bubble_ready1", 32'(push_ready[1]), 32'd0);
      end
      set_src(0, 1'b1, 1'b1, 8'hB1);
      step("bub_last", acc);
      check("bub_last_src", 32'(acc), 32'd0);
      push_valid = '0;

      // Backpressure with priority at 1: sources 1 and 2 valid, no accepts
      set_src(1, 1'b1, 1'b1, 8'hD1);
      set_src(2, 1'b1, 1'b1, 8'hD2);
      pop_ready = 1'b0;
      for (int i = 0; i < 5; i++) step("bp", acc);
      pop_ready = 1'b1;
      step("bp_release", acc);
      check("bp_release_src", 32'(acc), 32'd1);
      push_valid[1] = 1'b0;

      // Wrap: source 2 completes, next pick among {0,1} must be 0
      step("wrap", acc);
      check("wrap_src", 32'(acc), 32'd2);
      push_valid = '0;
      set_src(0, 1'b1, 1'b1, 8'hE0);
      set_src(1, 1'b1, 1'b1, 8'hE1);
      step("wrap_next", acc);
      check("wrap_next_src", 32'(acc), 32'd0);
      push_valid = '0;

      // Asynchronous reset while locked to source 1
      set_src(1, 1'b1, 1'b0, 8'hF1);
      step("rst_lock", acc);
      check("rst_lock_src", 32'(acc), 32'd1);
      push_valid = '0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_async_locked", 32'(locked), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      push_valid = 3'b111;
      push_last  = 3'b111;
      step("rst_after", acc);
      check("rst_after_src", 32'(acc), 32'd0);
      push_valid = '0;

      // Random packet traffic with random backpressure and inter-beat bubbles
      for (int i = 0; i < 600; i++) begin
         pop_ready = ($urandom_range(0, 3) != 0);
         for (int s = 0; s < N; s++) begin
            if (!push_valid[s] && $urandom_range(0, 2) != 0) begin
               if (rem[s] == 0) rem[s] = $urandom_range(1, 4);
               set_src(s, 1'b1, rem[s] == 1, 8'($urandom));
            end
         end
         step("rnd", acc);
         if (acc >= 0) begin
            rem[acc]--;
            push_valid[acc] = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/br_arb_rr_packet_lock.md
# br_arb_rr_packet_lock

Round-robin packet arbiter that shares one valid/ready channel among `NumRequesters` upstream sources. Arbitration happens only at packet boundaries. Once a source wins the first beat of a multi-beat packet, the grant stays locked to that source until its `last` beat is accepted. Round-robin priority advances only when a packet completes. The block sits between N packet producers and a single downstream consumer and is purely flow-controlled: no internal data storage.

## Interface
- `NumRequesters`, default 2: number of upstream sources; must be ≥ 2.
- `DataWidth`, default 8: payload width per beat; must be ≥ 1.
- `SrcWidth`, derived as `$clog2(NumRequesters)`: width of `pop_src`; not overridable.

- `clk` in 1: the only clock; all state is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `push_valid` in N: per-source beat valid.
- `push_ready` out N: per-source beat accept.
- `push_data` in N*DataWidth: source i occupies bits `[i*DataWidth +: DataWidth]`.
- `push_last` in N: per-source end-of-packet marker, qualified by `push_valid`.
- `pop_valid` out 1: downstream beat valid.
- `pop_ready` in 1: downstream accept.
- `pop_data` out DataWidth: muxed payload of the granted source.
- `pop_last` out 1: muxed `last` of the granted source.
- `pop_src` out SrcWidth: index of the granted source.
- `locked` out 1: registered; 1 while a packet is in progress (first beat accepted, last beat not yet accepted).

## Operation
- State:
  - `locked` (1 bit).
  - `owner` (SrcWidth bits).
  - `prio` (SrcWidth bits): index of the highest-priority source.
  - Reset values: `locked`=0, `owner`=0, `prio`=0.
- UNLOCKED (`locked`=0):
  - The grant is a combinational round-robin pick over `push_valid`.
  - Search order is `prio`, `prio+1`, …, N-1, 0, …, `prio-1`, wrapping mod N.
  - Exactly one grant is asserted when any `push_valid` is set; the grant is all-zero otherwise.
- LOCKED (`locked`=1):
  - The grant is `owner` if `push_valid[owner]`, else none.
  - All other sources are masked, even if valid.
  - If the owner deasserts `push_valid` mid-packet, the channel bubbles: `pop_valid`=0 and the lock is held.
- Outputs (combinational):
  - `pop_valid` = OR of the grant.
  - `push_ready[i]` = grant[i] && `pop_ready`.
  - `pop_data`, `pop_last` and `pop_src` select the granted source.
  - When nothing is granted, `pop_data`, `pop_last` and `pop_src` are 0.
- Accept = `pop_valid && pop_ready`.
- Transitions, applied on an accepted beat from granted source g:
  - UNLOCKED, `pop_last`=0: move to LOCKED and set `owner`=g.
  - UNLOCKED, `pop_last`=1 (single-beat packet): stay UNLOCKED and set `prio`=(g+1) mod N.
  - LOCKED, `pop_last`=0: no state change.
  - LOCKED, `pop_last`=1: move to UNLOCKED and set `prio`=(`owner`+1) mod N.
- `prio` never changes on non-last beats or idle cycles.
- Wrap: when g=N-1, `prio` becomes 0. When N is not a power of 2, `prio` must never take values ≥ N.
- Fairness guarantee: a source holding `push_valid` waits at most N-1 complete packets from other sources before its first beat is granted.
- Upstream contract: the source holds `valid`, `data` and `last` stable until accepted. The block does not check this. Violations give undefined grants but must never assert more than one `push_ready`.
- Reset mid-packet:
  - The lock is dropped asynchronously and `prio` returns to 0.
  - The partial packet is abandoned. Recovery is the system's responsibility.
- Invariants (formal targets):
  - At most one bit of `push_ready` is set (onehot0).
  - `push_ready` is nonzero only when `pop_ready` is 1.
  - While `locked`=1, `pop_src` equals `owner` whenever `pop_valid` is 1.

## Timing
- Zero-cycle latency: `push_*` to `pop_*` and `pop_ready` to `push_ready` are combinational. There are no internal buffers.
- `locked`, `owner` and `prio` update on the rising `clk` edge that follows the accept cycle. The next beat's arbitration uses the updated state.
- Back-to-back packets from different sources are allowed with no bubble: the last beat of A and the first beat of B land on consecutive cycles.
- During reset, the state is at its reset values and the outputs follow that state combinationally. This means `pop_valid` mirrors `push_valid` with `prio`=0. Benches keep `push_valid`=0 while `rst_n`=0.

## Test plan
- Single-beat round robin, N=4:
  - Stimulus: all `push_valid`=1 and `push_last`=1, `pop_ready`=1 for 8 cycles.
  - Required: `pop_src` sequence 0,1,2,3,0,1,2,3; `locked` stays 0.
- Packet lock, N=4:
  - Stimulus: source 2 sends a 3-beat packet while sources 0 and 3 hold valid.
  - Required: `pop_src`=2 for 3 accepted beats; `locked`=1 after beat 1 and 0 after beat 3; the next grant is source 3.
- Bubble inside packet, N=2:
  - Stimulus: source 0's first beat is accepted, then source 0 drops valid for 2 cycles while source 1 is valid.
  - Required: `pop_valid`=0 for those 2 cycles, `push_ready[1]`=0 throughout, and the lock holds until source 0's last beat.
- Backpressure:
  - Stimulus: `pop_ready`=0 for 5 cycles with sources 1 and 2 valid; `prio`=1.
  - Required: `pop_src`=1 is stable, all `push_ready`=0, and no state change.
- Wrap and non-power-of-2, N=3:
  - Stimulus: a single-beat packet from source 2 is accepted.
  - Required: `prio`=0; the next grant among {0,1} is 0.
- Async reset mid-packet:
  - Stimulus: assert `rst_n`=0 while `locked`=1 with `owner`=1, then release.
  - Required: `locked`=0 immediately; the first grant after reset with all sources valid is source 0.
